// File: rtl/trng_cond_sched.sv
// trng_cond_sched: sequences the SHA-256 conditioning core of the TRNG.
// Gathers sixteen 32-bit raw entropy words into a 512-bit block. It holds
// sha_go and the block stable until the core reports done, then captures the
// digest. The digest is offered downstream on a valid/ready handshake.
// Health-test failures discard the partial block, or taint the hash in
// flight. A watchdog locks the block if the core never finishes.
module trng_cond_sched #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ent_valid,
  input  logic [WORD_W-1:0] ent_data,
  output logic              ent_ready,
  input  logic              health_fail,
  output logic              sha_go,
  output logic [511:0]      sha_data_in,
  input  logic [255:0]      sha_data_out,
  input  logic              sha_done,
  output logic              rnd_valid,
  output logic [255:0]      rnd_data,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  blocks_done
);

  localparam int BLOCK_W = 512;
  localparam int WORDS   = BLOCK_W / WORD_W;
  localparam int WC_W    = $clog2(WORDS);
  localparam int TO_W    = 10;

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);
  // The HASH cycle that starts with TO_LAST on the counter is the
  // TIMEOUT-th one, so the watchdog trips at the end of that cycle.
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_HASH  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;

  logic [2:0]         state_q,    state_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
  logic               taint_q,    taint_d;
  logic [BLOCK_W-1:0] data_q,     data_d;
  logic [255:0]       digest_q,   digest_d;
  logic               timeout_q,  timeout_d;
  logic [CNT_W-1:0]   blocks_q,   blocks_d;

  // Handshake and status outputs decode straight from the state register.
  // A reset therefore clears them at once, without waiting for a clock edge.
  assign ent_ready   = (state_q == S_FILL) & enable & ~health_fail;
  assign sha_go      = (state_q == S_HASH);
  assign rnd_valid   = (state_q == S_OUT);
  assign busy        = (state_q != S_IDLE);
  assign sha_data_in = data_q;
  assign rnd_data    = digest_q;
  assign timeout_err = timeout_q;
  assign blocks_done = blocks_q;

  // Next-state logic for the sequencer, the counters and the data path.
  always_comb begin
    // NOTE: every target gets its hold value first. Then no path through the
    // case statement leaves a signal unassigned, and no latch is inferred.
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    to_cnt_d   = to_cnt_q;
    taint_d    = taint_q;
    data_d     = data_q;
    digest_d   = digest_q;
    timeout_d  = timeout_q;
    blocks_d   = blocks_q;

    case (state_q)
      S_IDLE: begin
        if (enable && !timeout_q) state_d = S_FILL;
      end

      S_FILL: begin
        if (!enable) begin
          word_cnt_d = '0;
          state_d    = S_IDLE;
        end else if (health_fail) begin
          // Throw away the partial block. The next accepted word starts a
          // new block as word 0.
          word_cnt_d = '0;
        end else if (ent_valid) begin
          // Words enter at the LSB end and move up one slot per accept.
          // After sixteen accepts, word 0 sits in [511:480] and word 15
          // in [31:0]. That matches an indexed write into slot
          // 511-32k, without a wide write-select mux.
          data_d = {data_q[BLOCK_W-WORD_W-1:0], ent_data};
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            to_cnt_d   = '0;
            state_d    = S_HASH;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
      end

      S_HASH: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (health_fail) taint_d = 1'b1;
        if (sha_done) begin
          to_cnt_d = '0;
          // A failure in the done cycle itself still taints the block.
          if (!(taint_q || health_fail)) digest_d = sha_data_out;
          state_d = S_DRAIN;
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d  = '0;
          timeout_d = 1'b1;
          state_d   = S_LOCK;
        end
      end

      S_DRAIN: begin
        // Wait for the core to drop done before committing. This stops a
        // stale done from being taken as the end of the next hash.
        if (!sha_done) begin
          if (taint_q) begin
            taint_d = 1'b0;
            state_d = enable ? S_FILL : S_IDLE;
          end else begin
            state_d = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (rnd_ready) begin
          blocks_d = blocks_q + CNT_W'(1);
          state_d  = enable ? S_FILL : S_IDLE;
        end
      end

      S_LOCK: begin
        // Only reset leaves LOCK.
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      to_cnt_q   <= '0;
      taint_q    <= 1'b0;
      // NOTE: the wide block and digest registers are reset on purpose. They
      // drive sha_data_in and rnd_data directly, and those outputs must read
      // zero after reset.
      data_q     <= '0;
      digest_q   <= '0;
      timeout_q  <= 1'b0;
      blocks_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples the
      // same pre-edge values no matter what order the statements are in.
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      to_cnt_q   <= to_cnt_d;
      taint_q    <= taint_d;
      data_q     <= data_d;
      digest_q   <= digest_d;
      timeout_q  <= timeout_d;
      blocks_q   <= blocks_d;
    end
  end

endmodule

// File: tb/tb_trng_cond_sched.sv
// Directed and randomized bench for trng_cond_sched. A behavioural hash-core
// model answers sha_go and records each digest it returns. The bench keeps its
// own view of which entropy words belong to the current block, of the digests
// it expects, and of the number of blocks delivered.
module tb_trng_cond_sched;

  localparam int TIMEOUT = 1023;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         ent_valid;
  logic [31:0]  ent_data;
  logic         ent_ready;
  logic         health_fail;
  logic         sha_go;
  logic [511:0] sha_data_in;
  logic [255:0] sha_data_out;
  logic         sha_done;
  logic         rnd_valid;
  logic [255:0] rnd_data;
  logic         rnd_ready;
  logic         busy;
  logic         timeout_err;
  logic [15:0]  blocks_done;

  trng_cond_sched dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .ent_valid    (ent_valid),
    .ent_data     (ent_data),
    .ent_ready    (ent_ready),
    .health_fail  (health_fail),
    .sha_go       (sha_go),
    .sha_data_in  (sha_data_in),
    .sha_data_out (sha_data_out),
    .sha_done     (sha_done),
    .rnd_valid    (rnd_valid),
    .rnd_data     (rnd_data),
    .rnd_ready    (rnd_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .blocks_done  (blocks_done)
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           done_cyc = -100;
  int           core_lat = 65;
  bit           core_hang = 0;
  int           exp_blocks = 0;
  logic [255:0] dig_q[$];
  logic [255:0] last_dig;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Hash-core model: raises done core_lat cycles after go is seen. It returns
  // a fresh random digest, and drops done as soon as go falls.
  initial begin
    int go_cycles;
    go_cycles    = 0;
    sha_done     = 1'b0;
    sha_data_out = '0;
    forever begin
      @(negedge clk);
      if (sha_go) begin
        if (!core_hang && go_cycles == core_lat) begin
          sha_done     = 1'b1;
          sha_data_out = rand256();
          dig_q.push_back(sha_data_out);
          done_cyc     = cyc;
        end
        go_cycles++;
      end else begin
        sha_done  = 1'b0;
        go_cycles = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams words until 16 have been accepted with enable=1. Optionally
  // raises health_fail when hf_at words have been taken, which discards them.
  // Ends one cycle after the last accept, where the hash must be running on
  // exactly the block kept by the bench.
  task automatic feed_block(input bit seq, input int hf_at, output logic [511:0] blk);
    logic [31:0] acc[$];
    bit failed;
    failed = 0;
    for (int guard = 0; guard < 200 && acc.size() < 16; guard++) begin
      @(negedge clk);
      health_fail = (!failed && hf_at >= 0 && acc.size() == hf_at);
      ent_valid   = 1'b1;
      ent_data    = seq ? 32'(acc.size()) : $urandom;
      #1;
      if (health_fail) begin
        check("ent_ready_on_health_fail", ent_ready, 0);
        acc.delete();
        failed = 1;
      end else begin
        check("ent_ready_fill", ent_ready, 1);
        acc.push_back(ent_data);
      end
    end
    @(negedge clk);
    ent_valid   = 1'b0;
    health_fail = 1'b0;
    #1;
    blk = '0;
    for (int k = 0; k < 16; k++) blk[511-32*k -: 32] = acc[k];
    check("sha_go_after_last_word", sha_go, 1);
    check("sha_data_in_block", sha_data_in, blk);
    check("ent_ready_in_hash", ent_ready, 0);
  endtask

  // Waits for rnd_valid. Then checks the latency from done and the digest
  // the core returned.
  task automatic wait_output();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #1;
      if (rnd_valid) begin
        ok = 1;
        break;
      end
    end
    check("rnd_valid_seen", ok, 1);
    check("digest_issued", dig_q.size() != 0, 1);
    if (ok && dig_q.size() != 0) begin
      last_dig = dig_q.pop_front();
      check("done_to_valid_cycles", cyc - done_cyc, 2);
      check("rnd_data_digest", rnd_data, last_dig);
    end
  endtask

  // Holds rnd_ready low for a while, offering entropy the whole time. It can
  // drop enable part-way, then completes one handshake.
  task automatic take_output(input int hold, input bit drop_en);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ent_valid = 1'b1;
      ent_data  = $urandom;
      if (drop_en && i == hold / 2) enable = 1'b0;
      #1;
      check("hold_rnd_valid", rnd_valid, 1);
      check("hold_rnd_data", rnd_data, last_dig);
      check("hold_ent_ready", ent_ready, 0);
    end
    @(negedge clk);
    ent_valid = 1'b0;
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
    #1;
    exp_blocks++;
    check("hs_rnd_valid_low", rnd_valid, 0);
    check("hs_blocks_done", blocks_done, exp_blocks);
    if (enable) check("hs_fill_resumes", ent_ready, 1);
    else        check("hs_idle", busy, 0);
  endtask

  initial begin
    logic [511:0] blk;
    int go_cnt;
    bit seen;
    bit lock_ok;

    rst = 1'b1; enable = 1'b0; ent_valid = 1'b0; ent_data = '0;
    health_fail = 1'b0; rnd_ready = 1'b0;

    // Reset state.
    #2 rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_sha_go", sha_go, 0);
    check("rst_rnd_valid", rnd_valid, 0);
    check("rst_ent_ready", ent_ready, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_blocks_done", blocks_done, 0);
    check("rst_rnd_data", rnd_data, 0);
    check("rst_sha_data_in", sha_data_in, 0);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    enable = 1'b1;

    // Nominal block: words 0..15, core done after 65 cycles, instant accept.
    core_lat = 65;
    feed_block(1, -1, blk);
    check("nominal_word0_msb", sha_data_in[511:480], 32'h0);
    check("nominal_word15_lsb", sha_data_in[31:0], 32'hF);
    wait_output();
    take_output(0, 0);

    // Backpressure: rnd_ready low for 20 cycles on a random block.
    core_lat = $urandom_range(10, 40);
    feed_block(0, -1, blk);
    wait_output();
    take_output(20, 0);

    // Health fail while word 9 is offered: restart the block.
    core_lat = $urandom_range(5, 30);
    feed_block(0, 9, blk);
    wait_output();
    take_output(1, 0);

    // Health fail pulse mid-hash: the digest is dropped and FILL resumes.
    core_lat = 40;
    feed_block(0, -1, blk);
    repeat (10) @(negedge clk);
    health_fail = 1'b1;
    @(negedge clk);
    health_fail = 1'b0;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (rnd_valid) seen = 1;
    end
    check("taint_no_rnd_valid", seen, 0);
    check("taint_blocks_unchanged", blocks_done, exp_blocks);
    check("taint_back_to_fill", ent_ready, 1);
    check("taint_digest_issued", dig_q.size(), 1);
    if (dig_q.size() != 0) void'(dig_q.pop_front());
    core_lat = $urandom_range(0, 20);
    feed_block(0, -1, blk);
    wait_output();
    take_output(3, 0);

    // Enable dropped partway through FILL discards the partial block.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ent_valid = 1'b1;
      ent_data  = $urandom;
    end
    @(negedge clk);
    ent_valid = 1'b0;
    enable    = 1'b0;
    @(negedge clk);
    #1;
    check("fill_enable_drop_idle", busy, 0);
    enable = 1'b1;
    feed_block(0, -1, blk);
    wait_output();
    // Enable falls while the output is pending: valid must hold, then IDLE.
    take_output(8, 1);
    @(negedge clk);
    enable = 1'b1;

    // Randomized blocks: random words, core latency and ready delay.
    for (int b = 0; b < 4; b++) begin
      core_lat = $urandom_range(0, 90);
      feed_block(0, -1, blk);
      wait_output();
      take_output($urandom_range(0, 6), 0);
    end

    // Watchdog: the core never finishes.
    core_hang = 1;
    feed_block(0, -1, blk);
    go_cnt = 1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      #1;
      if (sha_go) go_cnt++;
      else break;
    end
    check("wd_hash_cycles", go_cnt, TIMEOUT);
    check("wd_timeout_err", timeout_err, 1);
    check("wd_sha_go_low", sha_go, 0);
    check("wd_busy", busy, 1);
    lock_ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enable    = (i >= 5);
      ent_valid = 1'b1;
      rnd_ready = 1'b1;
      #1;
      if (!(busy === 1'b1 && ent_ready === 1'b0 && sha_go === 1'b0 &&
            rnd_valid === 1'b0 && timeout_err === 1'b1)) lock_ok = 0;
    end
    ent_valid = 1'b0;
    rnd_ready = 1'b0;
    check("lock_ignores_enable", lock_ok, 1);
    check("lock_blocks_unchanged", blocks_done, exp_blocks);
    #2 rst = 1'b0;
    #1;
    check("lock_rst_timeout_err", timeout_err, 0);
    check("lock_rst_busy", busy, 0);
    check("lock_rst_blocks_done", blocks_done, 0);
    exp_blocks = 0;
    core_hang  = 0;
    @(negedge clk);
    rst = 1'b1;

    // Async reset while an output is pending.
    core_lat = $urandom_range(5, 25);
    feed_block(0, -1, blk);
    wait_output();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_rnd_valid", rnd_valid, 0);
    check("async_rst_sha_go", sha_go, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rnd_data", rnd_data, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
